// File: rtl/cplx_div_arbiter_pkg.sv
// Shared constants and types for the complex-divide arbiter.
package cplx_div_arbiter_pkg;

  // Default operand width per component and datapath latency.
  localparam int unsigned DefW   = 32;
  localparam int unsigned DefLat = 3;

  // Component slot indices inside a 4W-bit op word {Real_A, Im_A, Real_B, Im_B};
  // slot k occupies bits [k*W +: W].
  localparam int unsigned OpRaIdx = 3;
  localparam int unsigned OpIaIdx = 2;
  localparam int unsigned OpRbIdx = 1;
  localparam int unsigned OpIbIdx = 0;

  // Travels alongside the datapath so each result finds its way home.
  typedef struct packed {
    logic vld;  // slot holds an issued op
    logic id;   // issuing requester
    logic dbz;  // op trapped as divide-by-zero, datapath result is ignored
  } tag_t;

endpackage

// File: rtl/cplx_div_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. After any grant the other requester is favoured.
module cplx_div_arbiter_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // ptr_q names the requester that wins a tie.
  logic ptr_q, ptr_d;

  // Grant and pointer next-state; a lone request always wins.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (req_i[0] && (!req_i[1] || !ptr_q)) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
    if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  // Pointer register, requester 0 favoured out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cplx_div_arbiter.sv
// Shares one fixed-latency complex-divide datapath between two requesters.
// Accepted ops are registered onto dp_*; a tag shift register runs in step with
// the datapath and steers each result back to its issuer. Divide-by-zero ops are
// trapped here: they never raise dp_valid but still occupy a tag slot so responses
// stay in issue order at fixed latency.
module cplx_div_arbiter
  import cplx_div_arbiter_pkg::*;
#(
  parameter int unsigned W   = DefW,
  parameter int unsigned LAT = DefLat
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req0_valid_i,
  output logic           req0_ready_o,
  input  logic [4*W-1:0] req0_op_i,
  input  logic           req1_valid_i,
  output logic           req1_ready_o,
  input  logic [4*W-1:0] req1_op_i,
  output logic           dp_valid_o,
  output logic [W-1:0]   dp_real_a_o,
  output logic [W-1:0]   dp_im_a_o,
  output logic [W-1:0]   dp_real_b_o,
  output logic [W-1:0]   dp_im_b_o,
  input  logic [2*W-1:0] dp_out_i,
  output logic           resp0_valid_o,
  output logic           resp1_valid_o,
  output logic [2*W-1:0] resp_data_o,
  output logic           resp_dbz_o,
  output logic           busy_o
);

  logic [1:0]     gnt;
  logic           acc_vld;
  logic           acc_id;
  logic [4*W-1:0] acc_op;
  logic           acc_dbz;
  logic           dp_issue;

  logic           dp_valid_q;
  logic [W-1:0]   ra_q, ia_q, rb_q, ib_q;

  // Stage 0 lines up with dp_valid; stage LAT lines up with a valid dp_out.
  tag_t           tag_d [LAT+1];
  tag_t           tag_q [LAT+1];
  tag_t           resp_tag;

  cplx_div_arbiter_rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .req_i ({req1_valid_i, req0_valid_i}),
    .gnt_o (gnt)
  );

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];

  // Select the accepted op and flag a zero divisor.
  always_comb begin
    acc_vld  = gnt[0] | gnt[1];
    acc_id   = gnt[1];
    acc_op   = gnt[1] ? req1_op_i : req0_op_i;
    acc_dbz  = (acc_op[OpRbIdx*W +: W] == '0) && (acc_op[OpIbIdx*W +: W] == '0);
    dp_issue = acc_vld && !acc_dbz;
  end

  // Operand register; operands hold their last issued value between ops.
  always_ff @(posedge clock) begin
    if (reset) begin
      dp_valid_q <= 1'b0;
      ra_q       <= '0;
      ia_q       <= '0;
      rb_q       <= '0;
      ib_q       <= '0;
    end else begin
      dp_valid_q <= dp_issue;
      if (dp_issue) begin
        ra_q <= acc_op[OpRaIdx*W +: W];
        ia_q <= acc_op[OpIaIdx*W +: W];
        rb_q <= acc_op[OpRbIdx*W +: W];
        ib_q <= acc_op[OpIbIdx*W +: W];
      end
    end
  end

  assign dp_valid_o  = dp_valid_q;
  assign dp_real_a_o = ra_q;
  assign dp_im_a_o   = ia_q;
  assign dp_real_b_o = rb_q;
  assign dp_im_b_o   = ib_q;

  // Tag pipe next-state: new tag enters at stage 0, everything else shifts by one.
  always_comb begin
    tag_d[0] = '{vld: acc_vld, id: acc_id, dbz: acc_vld & acc_dbz};
    for (int unsigned i = 1; i <= LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Tag pipe register; reset drops every op in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i <= LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i <= LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Response stage is the last tag slot; dp_out is only looked at for live, non-trapped ops.
  always_comb begin
    resp_tag      = tag_q[LAT];
    resp0_valid_o = resp_tag.vld & ~resp_tag.id;
    resp1_valid_o = resp_tag.vld & resp_tag.id;
    resp_dbz_o    = resp_tag.vld & resp_tag.dbz;
    resp_data_o   = (resp_tag.vld && !resp_tag.dbz) ? dp_out_i : '0;
  end

  // Busy while any tag slot, including the response stage, is occupied.
  always_comb begin
    busy_o = 1'b0;
    for (int unsigned i = 0; i <= LAT; i++) begin
      busy_o = busy_o | tag_q[i].vld;
    end
  end

endmodule

// File: tb/tb_cplx_div_arbiter.sv
// Bench for cplx_div_arbiter: LAT-cycle datapath stub returning
// {A_real+B_real, A_im-B_im} and a queue-based reference model of arbitration,
// issue and response timing.
module tb_cplx_div_arbiter;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 3;

  logic           clock = 1'b0;
  logic           reset;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4*W-1:0] req0_op, req1_op;
  logic           dp_valid;
  logic [W-1:0]   dp_real_a, dp_im_a, dp_real_b, dp_im_b;
  logic [2*W-1:0] dp_out;
  logic           resp0_valid, resp1_valid, resp_dbz, busy;
  logic [2*W-1:0] resp_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  cplx_div_arbiter #(.W(W), .LAT(LAT)) dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid_i  (req0_valid),
    .req0_ready_o  (req0_ready),
    .req0_op_i     (req0_op),
    .req1_valid_i  (req1_valid),
    .req1_ready_o  (req1_ready),
    .req1_op_i     (req1_op),
    .dp_valid_o    (dp_valid),
    .dp_real_a_o   (dp_real_a),
    .dp_im_a_o     (dp_im_a),
    .dp_real_b_o   (dp_real_b),
    .dp_im_b_o     (dp_im_b),
    .dp_out_i      (dp_out),
    .resp0_valid_o (resp0_valid),
    .resp1_valid_o (resp1_valid),
    .resp_data_o   (resp_data),
    .resp_dbz_o    (resp_dbz),
    .busy_o        (busy)
  );

  // Datapath stub: result valid LAT cycles after dp_valid, junk otherwise.
  logic [2*W-1:0] stub_q [LAT];
  always @(posedge clock) begin
    stub_q[0] <= dp_valid ? {dp_real_a + dp_real_b, dp_im_a - dp_im_b}
                          : 64'hBAD0_0BAD_DEAD_BEEF;
    for (int i = 1; i < LAT; i++) stub_q[i] <= stub_q[i-1];
  end
  assign dp_out = stub_q[LAT-1];

  // ---------------- reference model ----------------
  typedef struct { int due; logic id; logic dbz; logic [2*W-1:0] data; } resp_t;
  typedef struct { int due; logic [4*W-1:0] ops; } issue_t;

  resp_t          rq[$];
  issue_t         iq[$];
  int             m_fav;
  logic           m_acc0, m_acc1;
  logic [1:0]     exp_gnt;
  logic           exp_dpv, exp_r0, exp_r1, exp_dbz, exp_busy;
  logic [4*W-1:0] exp_ops;
  logic [2*W-1:0] exp_data;

  task automatic model_clear();
    rq.delete();
    iq.delete();
    m_fav  = 0;
    m_acc0 = 1'b0;
    m_acc1 = 1'b0;
  endtask

  // Expected DUT outputs for the current cycle.
  task automatic model_eval();
    while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
    while (iq.size() > 0 && iq[0].due < cyc) void'(iq.pop_front());
    if (req0_valid && req1_valid) exp_gnt = (m_fav == 1) ? 2'b10 : 2'b01;
    else exp_gnt = {req1_valid, req0_valid};
    exp_dpv = (iq.size() > 0) && (iq[0].due == cyc);
    exp_ops = exp_dpv ? iq[0].ops : '0;
    exp_r0 = 1'b0; exp_r1 = 1'b0; exp_dbz = 1'b0; exp_data = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_r0   = !rq[0].id;
      exp_r1   = rq[0].id;
      exp_dbz  = rq[0].dbz;
      exp_data = rq[0].data;
    end
    exp_busy = (rq.size() > 0);
  endtask

  // Record what the clock edge ending this cycle does to the model.
  task automatic model_commit();
    logic           id, dz;
    logic [4*W-1:0] op;
    logic [W-1:0]   ra, ia, rb, ib;
    m_acc0 = 1'b0;
    m_acc1 = 1'b0;
    if (reset) begin
      model_clear();
      return;
    end
    if (exp_gnt != 2'b00) begin
      id = exp_gnt[1];
      op = id ? req1_op : req0_op;
      ra = op[127:96]; ia = op[95:64]; rb = op[63:32]; ib = op[31:0];
      dz = (rb == 0) && (ib == 0);
      rq.push_back('{due: cyc + LAT + 1, id: id, dbz: dz,
                     data: dz ? 64'd0 : {ra + rb, ia - ib}});
      if (!dz) iq.push_back('{due: cyc + 1, ops: op});
      m_fav  = id ? 0 : 1;
      m_acc0 = !id;
      m_acc1 = id;
    end
  endtask

  function automatic logic [6:0] obs_ctl();
    return {req1_ready, req0_ready, dp_valid, resp1_valid, resp0_valid, resp_dbz, busy};
  endfunction

  function automatic logic [6:0] exp_ctl();
    return {exp_gnt, exp_dpv, exp_r1, exp_r0, exp_dbz, exp_busy};
  endfunction

  function automatic logic [4*W-1:0] dp_ops();
    return {dp_real_a, dp_im_a, dp_real_b, dp_im_b};
  endfunction

  // Random op; about a quarter are divide-by-zero, some have only one zero divisor half.
  function automatic logic [4*W-1:0] rand_op();
    logic [W-1:0] ra, ia, rb, ib;
    int unsigned  k;
    ra = $urandom; ia = $urandom; rb = $urandom; ib = $urandom;
    k  = $urandom_range(7);
    if (k < 2) begin
      rb = '0; ib = '0;
    end else if (k == 2) begin
      rb = '0;
    end else if (k == 3) begin
      ib = '0;
    end
    return {ra, ia, rb, ib};
  endfunction

  // Valid/ready-respecting random requesters: hold an op until it is accepted.
  task automatic drive_rand(int p0, int p1);
    if (!req0_valid || m_acc0) begin
      req0_valid = (int'($urandom_range(99)) < p0);
      req0_op    = rand_op();
    end
    if (!req1_valid || m_acc1) begin
      req1_valid = (int'($urandom_range(99)) < p1);
      req1_op    = rand_op();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req0_op = '0; req1_op = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      model_eval();
      checks++;
      if (obs_ctl() !== 7'd0) begin
        failures++; $display("FAIL reset_ctl cyc=%0d got=%b want=0", cyc, obs_ctl());
      end
      checks++;
      if (resp_data !== '0) begin
        failures++; $display("FAIL reset_data cyc=%0d got=%h want=0", cyc, resp_data);
      end
      checks++;
      if (dp_ops() !== '0) begin
        failures++; $display("FAIL reset_ops cyc=%0d got=%h want=0", cyc, dp_ops());
      end
      model_commit();
      @(posedge clock); #1;
    end
  endtask

  task automatic test_single();
    int             acc_cyc, resp_cyc;
    logic [2*W-1:0] resp_val;
    acc_cyc = -1; resp_cyc = -1; resp_val = '0;
    req0_valid = 1'b1; req0_op = {32'd5, 32'd7, 32'd1, 32'd2}; req1_valid = 1'b0;
    for (int i = 0; i < int'(LAT) + 4; i++) begin
      @(negedge clock);
      model_eval();
      if (i == 0) acc_cyc = cyc;
      if (resp0_valid) begin resp_cyc = cyc; resp_val = resp_data; end
      checks++;
      if (obs_ctl() !== exp_ctl()) begin
        failures++; $display("FAIL single_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl(), exp_ctl());
      end
      checks++;
      if (resp_data !== exp_data) begin
        failures++; $display("FAIL single_data cyc=%0d got=%h want=%h", cyc, resp_data, exp_data);
      end
      if (exp_dpv) begin
        checks++;
        if (dp_ops() !== exp_ops) begin
          failures++; $display("FAIL single_ops cyc=%0d got=%h want=%h", cyc, dp_ops(), exp_ops);
        end
      end
      model_commit();
      @(posedge clock); #1;
      req0_valid = 1'b0;
    end
    checks++;
    if (resp_cyc !== acc_cyc + int'(LAT) + 1) begin
      failures++; $display("FAIL single_latency got=%0d want=%0d", resp_cyc, acc_cyc + LAT + 1);
    end
    checks++;
    if (resp_val !== {32'd6, 32'd5}) begin
      failures++; $display("FAIL single_result got=%h want=%h", resp_val, {32'd6, 32'd5});
    end
  endtask

  task automatic test_alternate();
    apply_reset();
    req0_valid = 1'b1; req0_op = rand_op();
    req1_valid = 1'b1; req1_op = rand_op();
    for (int i = 0; i < int'(LAT) + 7; i++) begin
      @(negedge clock);
      model_eval();
      if (i < 4) begin
        checks++;
        if ({req1_ready, req0_ready} !== ((i % 2) ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL alt_grant i=%0d got=%b want=%b", i, {req1_ready, req0_ready},
                   (i % 2) ? 2'b10 : 2'b01);
        end
      end
      checks++;
      if (obs_ctl() !== exp_ctl()) begin
        failures++; $display("FAIL alt_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl(), exp_ctl());
      end
      checks++;
      if (resp_data !== exp_data) begin
        failures++; $display("FAIL alt_data cyc=%0d got=%h want=%h", cyc, resp_data, exp_data);
      end
      if (exp_dpv) begin
        checks++;
        if (dp_ops() !== exp_ops) begin
          failures++; $display("FAIL alt_ops cyc=%0d got=%h want=%h", cyc, dp_ops(), exp_ops);
        end
      end
      model_commit();
      @(posedge clock); #1;
      if (m_acc0) req0_op = rand_op();
      if (m_acc1) req1_op = rand_op();
      req0_valid = (i < 3);
      req1_valid = (i < 3);
    end
  endtask

  task automatic test_dbz();
    int acc_cyc, resp_cyc, dpv_seen;
    logic [2*W-1:0] resp_val;
    acc_cyc = -1; resp_cyc = -1; dpv_seen = 0; resp_val = '1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = {32'($urandom), 32'($urandom), 32'd0, 32'd0};
    for (int i = 0; i < int'(LAT) + 4; i++) begin
      @(negedge clock);
      model_eval();
      if (i == 0) acc_cyc = cyc;
      if (dp_valid) dpv_seen++;
      if (resp1_valid && resp_dbz) begin resp_cyc = cyc; resp_val = resp_data; end
      checks++;
      if (obs_ctl() !== exp_ctl()) begin
        failures++; $display("FAIL dbz_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl(), exp_ctl());
      end
      checks++;
      if (resp_data !== exp_data) begin
        failures++; $display("FAIL dbz_data cyc=%0d got=%h want=%h", cyc, resp_data, exp_data);
      end
      model_commit();
      @(posedge clock); #1;
      req1_valid = 1'b0;
    end
    checks++;
    if (dpv_seen !== 0) begin
      failures++; $display("FAIL dbz_no_issue got=%0d want=0", dpv_seen);
    end
    checks++;
    if (resp_cyc !== acc_cyc + int'(LAT) + 1 || resp_val !== '0) begin
      failures++;
      $display("FAIL dbz_resp got cyc=%0d data=%h want cyc=%0d data=0", resp_cyc, resp_val,
               acc_cyc + LAT + 1);
    end
  endtask

  task automatic test_sandwich();
    logic [4*W-1:0] ops [3];
    ops[0] = {32'd100, 32'd50, 32'd3, 32'd4};
    ops[1] = {32'd9, 32'd8, 32'd0, 32'd0};
    ops[2] = {32'd20, 32'd30, 32'd0, 32'd7};
    req1_valid = 1'b0; req0_valid = 1'b1; req0_op = ops[0];
    for (int i = 0; i < int'(LAT) + 6; i++) begin
      @(negedge clock);
      model_eval();
      if (i >= int'(LAT) + 1 && i <= int'(LAT) + 3) begin
        checks++;
        if ({resp0_valid, resp_dbz} !== {1'b1, i == int'(LAT) + 2}) begin
          failures++;
          $display("FAIL sandwich_seq i=%0d got=%b want=%b", i, {resp0_valid, resp_dbz},
                   {1'b1, i == int'(LAT) + 2});
        end
      end
      checks++;
      if (obs_ctl() !== exp_ctl()) begin
        failures++; $display("FAIL sandwich_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl(), exp_ctl());
      end
      checks++;
      if (resp_data !== exp_data) begin
        failures++;
        $display("FAIL sandwich_data cyc=%0d got=%h want=%h", cyc, resp_data, exp_data);
      end
      if (exp_dpv) begin
        checks++;
        if (dp_ops() !== exp_ops) begin
          failures++; $display("FAIL sandwich_ops cyc=%0d got=%h want=%h", cyc, dp_ops(), exp_ops);
        end
      end
      model_commit();
      @(posedge clock); #1;
      req0_valid = (i < 2);
      if (i < 2) req0_op = ops[i+1];
    end
  endtask

  task automatic test_reset_midop();
    int resp_seen;
    resp_seen = 0;
    req1_valid = 1'b0; req0_valid = 1'b1;
    req0_op = {32'($urandom) | 32'd1, 32'($urandom), 32'd11, 32'($urandom)};
    for (int i = 0; i < int'(LAT) + 6; i++) begin
      @(negedge clock);
      model_eval();
      if (i >= 3 && (resp0_valid || resp1_valid)) resp_seen++;
      if (i == 3) begin
        checks++;
        if (obs_ctl() !== 7'd0 || resp_data !== '0 || dp_ops() !== '0) begin
          failures++;
          $display("FAIL midrst_zero got ctl=%b data=%h ops=%h want all 0", obs_ctl(),
                   resp_data, dp_ops());
        end
      end
      checks++;
      if (obs_ctl() !== exp_ctl()) begin
        failures++; $display("FAIL midrst_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl(), exp_ctl());
      end
      checks++;
      if (resp_data !== exp_data) begin
        failures++; $display("FAIL midrst_data cyc=%0d got=%h want=%h", cyc, resp_data, exp_data);
      end
      model_commit();
      @(posedge clock); #1;
      req0_valid = 1'b0;
      reset = (i == 1);
    end
    checks++;
    if (resp_seen !== 0) begin
      failures++; $display("FAIL midrst_no_resp got=%0d want=0", resp_seen);
    end
  endtask

  task automatic test_stream();
    req1_valid = 1'b0; req0_valid = 1'b1; req0_op = rand_op();
    for (int i = 0; i < int'(LAT) + 12; i++) begin
      @(negedge clock);
      model_eval();
      if (i < 8) begin
        checks++;
        if (req0_ready !== 1'b1) begin
          failures++; $display("FAIL stream_ready i=%0d got=%b want=1", i, req0_ready);
        end
      end
      if (i == 7 + int'(LAT) + 1 || i == 7 + int'(LAT) + 2) begin
        checks++;
        if (busy !== (i == 7 + int'(LAT) + 1)) begin
          failures++;
          $display("FAIL stream_busy i=%0d got=%b want=%b", i, busy, i == 7 + int'(LAT) + 1);
        end
      end
      checks++;
      if (obs_ctl() !== exp_ctl()) begin
        failures++; $display("FAIL stream_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl(), exp_ctl());
      end
      checks++;
      if (resp_data !== exp_data) begin
        failures++; $display("FAIL stream_data cyc=%0d got=%h want=%h", cyc, resp_data, exp_data);
      end
      if (exp_dpv) begin
        checks++;
        if (dp_ops() !== exp_ops) begin
          failures++; $display("FAIL stream_ops cyc=%0d got=%h want=%h", cyc, dp_ops(), exp_ops);
        end
      end
      model_commit();
      @(posedge clock); #1;
      req0_valid = (i < 7);
      req0_op    = rand_op();
    end
  endtask

  task automatic test_random();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 400 + int'(LAT) + 4; i++) begin
      @(negedge clock);
      model_eval();
      checks++;
      if (obs_ctl() !== exp_ctl()) begin
        failures++; $display("FAIL rand_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl(), exp_ctl());
      end
      checks++;
      if (resp_data !== exp_data) begin
        failures++; $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, resp_data, exp_data);
      end
      if (exp_dpv) begin
        checks++;
        if (dp_ops() !== exp_ops) begin
          failures++; $display("FAIL rand_ops cyc=%0d got=%h want=%h", cyc, dp_ops(), exp_ops);
        end
      end
      model_commit();
      @(posedge clock); #1;
      if (i < 400) begin
        drive_rand(70, 60);
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_dbz();
    test_sandwich();
    test_reset_midop();
    test_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
